evt_seq_dispatcher: RTL and testbench

Dispatcher that sits between the incoming spike event stream and a bank of `NUM_ENGINES` kernel-sweep sequencers. It accepts one spike ID at a time and assigns it round-robin to an idle engine. For each accepted spike it produces the engine-side handshake: an init pulse, `KERNEL_SIZE*KERNEL_SIZE` sweep grants (each carrying a spike event), then a retire grant once the engine raises ready. This lets several engines work on different spikes at the same time.

---
 rtl/sne_evt_stream_pkg.sv | 33 +++
 rtl/evt_seq_slot.sv | 99 +++++++++
 rtl/evt_seq_dispatcher.sv | 116 +++++++++++
 tb/tb_evt_seq_dispatcher.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sne_evt_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sne_evt_stream_pkg
//  Description : Shared types and sizing helpers for the spike event
//                dispatcher and its per-engine slots.
//  Revision    : 1.0 - initial release
// ============================================================================
package sne_evt_stream_pkg;

  // Lifecycle of one engine slot
  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_INIT  = 2'd1,
    SLOT_SWEEP = 2'd2,
    SLOT_DRAIN = 2'd3
  } slot_state_e;

  localparam int KERNEL_SIZE_DEFAULT = 3;
  localparam int KERNEL_STEPS        = KERNEL_SIZE_DEFAULT * KERNEL_SIZE_DEFAULT;
  localparam int STEP_WIDTH          = $clog2(KERNEL_STEPS);

  // Number of sweep steps for a given kernel edge length
  function automatic int kernel_steps(input int k);
    return k * k;
  endfunction

  // Step counter width; kept at least one bit for degenerate 1x1 kernels
  function automatic int step_width(input int k);
    return (k * k <= 2) ? 1 : $clog2(k * k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/evt_seq_slot.sv
`default_nettype none
// ============================================================================
//  Module      : evt_seq_slot
//  Description : One engine slot: IDLE -> INIT -> SWEEP -> DRAIN -> IDLE
//                lifecycle, sweep step counter and latched spike ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module evt_seq_slot
  import sne_evt_stream_pkg::*;
#(
  parameter int STREAM_ADDR_WIDTH = 16,
  parameter int KERNEL_SIZE       = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         load,
  input  logic [STREAM_ADDR_WIDTH-1:0] load_id,
  input  logic                         stall,
  input  logic                         ready,
  output logic                         init,
  output logic                         spike_evt,
  output logic                         grant,
  output logic                         retire,
  output logic                         idle,
  output logic                         busy,
  output logic [STREAM_ADDR_WIDTH-1:0] id
);

  localparam int SWEEP_STEPS = kernel_steps(KERNEL_SIZE);
  localparam int SW          = step_width(KERNEL_SIZE);
  localparam logic [SW-1:0] LAST_STEP = SW'(SWEEP_STEPS - 1);

  slot_state_e                  state_q, state_d;
  logic [SW-1:0]                step_q, step_d;
  logic [STREAM_ADDR_WIDTH-1:0] id_q;

  assign idle = (state_q == SLOT_IDLE);
  assign busy = ~idle;
  assign id   = id_q;

  // Next-state and engine handshake; flush overrides everything
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    init      = 1'b0;
    spike_evt = 1'b0;
    grant     = 1'b0;
    retire    = 1'b0;
    case (state_q)
      SLOT_IDLE: begin
        if (load) state_d = SLOT_INIT;
      end
      SLOT_INIT: begin
        init    = 1'b1;
        step_d  = '0;
        state_d = SLOT_SWEEP;
      end
      SLOT_SWEEP: begin
        grant     = ~stall;
        spike_evt = ~stall;
        if (!stall) begin
          step_d = step_q + SW'(1);
          if (step_q == LAST_STEP) state_d = SLOT_DRAIN;
        end
      end
      SLOT_DRAIN: begin
        grant = ready;
        if (ready) begin
          retire  = 1'b1;
          state_d = SLOT_IDLE;
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
    if (flush) begin
      state_d   = SLOT_IDLE;
      init      = 1'b0;
      spike_evt = 1'b0;
      grant     = 1'b0;
      retire    = 1'b0;
    end
  end

  // State, step counter and spike ID registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_IDLE;
      step_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (load && state_q == SLOT_IDLE) id_q <= load_id;
    end
  end

endmodule
`default_nettype wire

// File: rtl/evt_seq_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : evt_seq_dispatcher
//  Description : Round-robin dispatcher of spike IDs onto a bank of
//                kernel-sweep engine slots, with retired-event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module evt_seq_dispatcher
  import sne_evt_stream_pkg::*;
#(
  parameter int NUM_ENGINES       = 4,
  parameter int STREAM_ADDR_WIDTH = 16,
  parameter int KERNEL_SIZE       = KERNEL_SIZE_DEFAULT,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic                                           enable_i,
  input  logic                                           flush_i,
  input  logic                                           evt_valid_i,
  input  logic [STREAM_ADDR_WIDTH-1:0]                   evt_id_i,
  output logic                                           evt_ready_o,
  output logic [NUM_ENGINES-1:0]                         eng_init_o,
  output logic [NUM_ENGINES-1:0]                         eng_spike_evt_o,
  output logic [NUM_ENGINES-1:0]                         eng_grant_o,
  output logic [NUM_ENGINES-1:0][STREAM_ADDR_WIDTH-1:0]  eng_id_o,
  input  logic [NUM_ENGINES-1:0]                         eng_stall_i,
  input  logic [NUM_ENGINES-1:0]                         eng_ready_i,
  output logic [NUM_ENGINES-1:0]                         busy_o,
  output logic [CNT_WIDTH-1:0]                           retired_cnt_o
);

  localparam int PTR_WIDTH = $clog2(NUM_ENGINES);

  logic [NUM_ENGINES-1:0] eligible;
  logic [NUM_ENGINES-1:0] load;
  logic [NUM_ENGINES-1:0] retire;
  logic [PTR_WIDTH-1:0]   rr_ptr;
  logic [PTR_WIDTH-1:0]   winner;
  logic                   transfer;
  logic [CNT_WIDTH-1:0]   retire_sum;
  logic [CNT_WIDTH-1:0]   retired_cnt;

  assign evt_ready_o   = enable_i & ~flush_i & (|eligible);
  assign transfer      = evt_valid_i & evt_ready_o;
  assign retired_cnt_o = retired_cnt;

  // First eligible slot at or after rr_ptr, searching cyclically
  always_comb begin
    logic [PTR_WIDTH:0] probe;
    logic               taken;
    winner = rr_ptr;
    taken  = 1'b0;
    probe  = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      probe = {1'b0, rr_ptr} + (PTR_WIDTH+1)'(k);
      if (probe >= (PTR_WIDTH+1)'(NUM_ENGINES))
        probe = probe - (PTR_WIDTH+1)'(NUM_ENGINES);
      if (!taken && eligible[probe[PTR_WIDTH-1:0]]) begin
        winner = probe[PTR_WIDTH-1:0];
        taken  = 1'b1;
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_slot
      assign load[i] = transfer & (winner == PTR_WIDTH'(i));

      evt_seq_slot #(
        .STREAM_ADDR_WIDTH (STREAM_ADDR_WIDTH),
        .KERNEL_SIZE       (KERNEL_SIZE)
      ) u_slot (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (flush_i),
        .load      (load[i]),
        .load_id   (evt_id_i),
        .stall     (eng_stall_i[i]),
        .ready     (eng_ready_i[i]),
        .init      (eng_init_o[i]),
        .spike_evt (eng_spike_evt_o[i]),
        .grant     (eng_grant_o[i]),
        .retire    (retire[i]),
        .idle      (eligible[i]),
        .busy      (busy_o[i]),
        .id        (eng_id_o[i])
      );
    end
  endgenerate

  // Popcount of slots retiring this cycle
  always_comb begin
    retire_sum = '0;
    for (int i = 0; i < NUM_ENGINES; i++)
      retire_sum = retire_sum + CNT_WIDTH'(retire[i]);
  end

  // Round-robin pointer advances past each winner
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      rr_ptr <= '0;
    else if (transfer)
      rr_ptr <= (winner == PTR_WIDTH'(NUM_ENGINES - 1)) ? '0 : winner + PTR_WIDTH'(1);
  end

  // Retired-spike counter, wraps naturally
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      retired_cnt <= '0;
    else
      retired_cnt <= retired_cnt + retire_sum;
  end

endmodule
`default_nettype wire

// File: tb/tb_evt_seq_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_evt_seq_dispatcher
//  Description : Directed self-checking bench for evt_seq_dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_evt_seq_dispatcher;

  localparam int NE = 4;
  localparam int AW = 16;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, enable, flush, evt_valid, evt_ready;
  logic [AW-1:0]          evt_id;
  logic [NE-1:0]          init, spike, grant, stall, ready, busy;
  logic [NE-1:0][AW-1:0]  eng_id;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          exp_cnt;
  int total = 0;
  int bad   = 0;

  evt_seq_dispatcher #(
    .NUM_ENGINES(NE), .STREAM_ADDR_WIDTH(AW), .KERNEL_SIZE(3), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .flush_i(flush),
    .evt_valid_i(evt_valid), .evt_id_i(evt_id), .evt_ready_o(evt_ready),
    .eng_init_o(init), .eng_spike_evt_o(spike), .eng_grant_o(grant),
    .eng_id_o(eng_id), .eng_stall_i(stall), .eng_ready_i(ready),
    .busy_o(busy), .retired_cnt_o(cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; evt_valid = 1'b0;
    evt_id = '0; stall = '0; ready = '0;
    cyc(); cyc();
    rst_n = 1'b1; enable = 1'b1; exp_cnt = '0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; evt_valid = 1'b0;
    evt_id = '0; stall = '0; ready = '0;
    cyc(); cyc();
    total++; if (evt_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", evt_ready); end
    total++; if (busy !== 4'b0) begin bad++; $display("FAIL reset_busy got=%b want=0000", busy); end
    total++; if (init !== 4'b0 || grant !== 4'b0 || spike !== 4'b0) begin bad++; $display("FAIL reset_outs init=%b grant=%b spike=%b want=0", init, grant, spike); end
    total++; if (eng_id !== '0) begin bad++; $display("FAIL reset_id got=%h want=0", eng_id); end
    total++; if (cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
    rst_n = 1'b1; enable = 1'b1; #1;
    total++; if (evt_ready !== 1'b1) begin bad++; $display("FAIL reset_enable_ready got=%0b want=1", evt_ready); end
  endtask

  task automatic test_single();
    int ngr = 0;
    apply_reset();
    ready = 4'hF; evt_valid = 1'b1; evt_id = 16'h0305; #1;
    total++; if (evt_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0b want=1", evt_ready); end
    cyc(); evt_valid = 1'b0; #1;
    total++; if (init !== 4'b0001 || busy !== 4'b0001) begin bad++; $display("FAIL single_init init=%b busy=%b want=0001", init, busy); end
    for (int c = 2; c <= 12; c++) begin
      cyc();
      total++; if (grant !== {3'b0, (c <= 11)}) begin bad++; $display("FAIL single_grant c=%0d got=%b want=%b", c, grant, {3'b0, (c <= 11)}); end
      total++; if (spike !== {3'b0, (c <= 10)}) begin bad++; $display("FAIL single_spike c=%0d got=%b want=%b", c, spike, {3'b0, (c <= 10)}); end
      if (spike[0] && grant[0]) ngr++;
    end
    exp_cnt = exp_cnt + 1;
    total++; if (cnt !== exp_cnt) begin bad++; $display("FAIL single_cnt got=%0d want=%0d", cnt, exp_cnt); end
    total++; if (ngr != 9) begin bad++; $display("FAIL single_ngrants got=%0d want=9", ngr); end
    total++; if (eng_id[0] !== 16'h0305) begin bad++; $display("FAIL single_id got=%h want=0305", eng_id[0]); end
    total++; if (busy !== 4'b0) begin bad++; $display("FAIL single_idle got=%b want=0000", busy); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      evt_valid = 1'b1; evt_id = 16'h0010 + 16'(i); #1;
      total++; if (evt_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=%0b want=1", i, evt_ready); end
      cyc();
      total++; if (init !== 4'(1 << i)) begin bad++; $display("FAIL b2b_init i=%0d got=%b want=%b", i, init, 4'(1 << i)); end
    end
    evt_id = 16'h0014; #1;
    total++; if (evt_ready !== 1'b0 || busy !== 4'hF) begin bad++; $display("FAIL b2b_full ready=%0b busy=%b want 0/1111", evt_ready, busy); end
    for (int k = 0; k < 12; k++) begin
      cyc();
      total++; if (evt_ready !== 1'b0) begin bad++; $display("FAIL b2b_hold k=%0d got=%0b want=0", k, evt_ready); end
    end
    ready = 4'b0100; #1;
    total++; if (grant !== 4'b0100 || evt_ready !== 1'b0) begin bad++; $display("FAIL b2b_retire grant=%b ready=%0b want 0100/0", grant, evt_ready); end
    cyc(); ready = 4'b0; #1;
    exp_cnt = exp_cnt + 1;
    total++; if (evt_ready !== 1'b1 || busy !== 4'b1011) begin bad++; $display("FAIL b2b_eligible ready=%0b busy=%b want 1/1011", evt_ready, busy); end
    total++; if (cnt !== exp_cnt) begin bad++; $display("FAIL b2b_cnt got=%0d want=%0d", cnt, exp_cnt); end
    cyc(); evt_valid = 1'b0;
    total++; if (init !== 4'b0100 || eng_id[2] !== 16'h0014) begin bad++; $display("FAIL b2b_redispatch init=%b id=%h want 0100/0014", init, eng_id[2]); end
  endtask

  task automatic test_stall();
    int ngr = 0;
    int last = 0;
    logic exp_g;
    apply_reset();
    evt_valid = 1'b1; evt_id = 16'h0207; cyc(); evt_valid = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      stall = (c >= 6 && c <= 10) ? 4'b0001 : 4'b0000;
      if (c == 17) begin stall = 4'b0001; ready = 4'b0001; end
      #1;
      exp_g = ((c >= 2 && c <= 15) && !(c >= 6 && c <= 10)) || (c == 17);
      total++; if (grant[0] !== exp_g) begin bad++; $display("FAIL stall_grant c=%0d got=%0b want=%0b", c, grant[0], exp_g); end
      if (grant[0] && spike[0]) begin ngr++; last = c; end
      cyc();
    end
    ready = '0; stall = '0;
    exp_cnt = exp_cnt + 1;
    total++; if (ngr != 9 || last != 15) begin bad++; $display("FAIL stall_sweep grants=%0d last=%0d want 9/15", ngr, last); end
    total++; if (cnt !== exp_cnt || busy !== 4'b0) begin bad++; $display("FAIL stall_retire cnt=%0d busy=%b want %0d/0000", cnt, busy, exp_cnt); end
  endtask

  task automatic test_dual_retire();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      evt_valid = 1'b1; evt_id = 16'h0020 + 16'(i); cyc();
    end
    evt_valid = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    ready = 4'b1010; #1;
    total++; if (grant !== 4'b1010 || cnt !== exp_cnt) begin bad++; $display("FAIL dual_retire grant=%b cnt=%0d want 1010/%0d", grant, cnt, exp_cnt); end
    cyc(); ready = '0; #1;
    exp_cnt = exp_cnt + 2;
    total++; if (cnt !== exp_cnt) begin bad++; $display("FAIL dual_cnt got=%0d want=%0d", cnt, exp_cnt); end
    total++; if (busy !== 4'b0101 || evt_ready !== 1'b1) begin bad++; $display("FAIL dual_eligible busy=%b ready=%0b want 0101/1", busy, evt_ready); end
    evt_valid = 1'b1; evt_id = 16'h00A1; cyc();
    total++; if (init !== 4'b0010) begin bad++; $display("FAIL dual_pick1 got=%b want=0010", init); end
    evt_id = 16'h00A2; cyc(); evt_valid = 1'b0;
    total++; if (init !== 4'b1000) begin bad++; $display("FAIL dual_pick3 got=%b want=1000", init); end
    total++; if (eng_id[1] !== 16'h00A1 || eng_id[3] !== 16'h00A2) begin bad++; $display("FAIL dual_ids got=%h/%h want 00a1/00a2", eng_id[1], eng_id[3]); end
  endtask

  task automatic test_flush();
    apply_reset();
    evt_valid = 1'b1; evt_id = 16'h0031; cyc();
    evt_id = 16'h0032; cyc(); evt_valid = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    #1;
    total++; if (grant !== 4'b0011) begin bad++; $display("FAIL flush_pre grant=%b want=0011", grant); end
    flush = 1'b1; evt_valid = 1'b1; evt_id = 16'h0040; #1;
    total++; if (grant !== 4'b0 || spike !== 4'b0 || evt_ready !== 1'b0) begin bad++; $display("FAIL flush_cycle grant=%b spike=%b ready=%0b want 0", grant, spike, evt_ready); end
    cyc(); flush = 1'b0; #1;
    total++; if (busy !== 4'b0 || cnt !== exp_cnt || evt_ready !== 1'b1) begin bad++; $display("FAIL flush_after busy=%b cnt=%0d ready=%0b want 0000/%0d/1", busy, cnt, evt_ready, exp_cnt); end
    cyc(); evt_valid = 1'b0;
    total++; if (init !== 4'b0100 || eng_id[2] !== 16'h0040 || eng_id[0] !== 16'h0031) begin bad++; $display("FAIL flush_accept init=%b id2=%h id0=%h want 0100/0040/0031", init, eng_id[2], eng_id[0]); end
  endtask

  task automatic test_enable();
    apply_reset();
    ready = 4'b0001;
    evt_valid = 1'b1; evt_id = 16'h0050; cyc();
    enable = 1'b0; evt_id = 16'h0051;
    for (int c = 1; c <= 12; c++) begin
      #1;
      total++; if (evt_ready !== 1'b0 || busy[3:1] !== 3'b0) begin bad++; $display("FAIL enable_gate c=%0d ready=%0b busy=%b want 0/000x", c, evt_ready, busy); end
      if (c == 11) begin
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL enable_retire got=%b want=0001", grant); end
      end
      cyc();
    end
    exp_cnt = exp_cnt + 1;
    total++; if (cnt !== exp_cnt || busy !== 4'b0) begin bad++; $display("FAIL enable_done cnt=%0d busy=%b want %0d/0000", cnt, busy, exp_cnt); end
    evt_valid = 1'b0; enable = 1'b1; ready = '0;
  endtask

  task automatic test_reset_mid();
    evt_valid = 1'b1; evt_id = 16'h0060; cyc(); evt_valid = 1'b0;
    total++; if (init !== 4'b0010) begin bad++; $display("FAIL rmid_pre got=%b want=0010", init); end
    cyc(); cyc(); cyc();
    rst_n = 1'b0; cyc(); rst_n = 1'b1; #1;
    total++; if (busy !== 4'b0 || cnt !== '0 || eng_id !== '0) begin bad++; $display("FAIL rmid_clear busy=%b cnt=%0d id=%h want 0", busy, cnt, eng_id); end
    evt_valid = 1'b1; evt_id = 16'h0061; cyc(); evt_valid = 1'b0;
    total++; if (init !== 4'b0001) begin bad++; $display("FAIL rmid_ptr got=%b want=0001", init); end
  endtask

  initial begin
    exp_cnt = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_dual_retire();
    test_flush();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
